// File: rtl/mdu_pkg.sv
// Shared M-extension MDU definitions: funct3 op codes, issue-FSM states and the
// locally computed divide-by-zero result.
package mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_LOCAL,
      ST_DRAIN
   } issue_state_t;

   // RISC-V divide by zero: quotient is all ones, remainder is the dividend.
   function automatic logic [31:0] div0_result(input logic [2:0] op, input logic [31:0] rs1);
      logic [31:0] res;
      case (op)
         OP_DIV, OP_DIVU: res = '1;
         default:         res = rs1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mdu_issue_if.sv
// Request/writeback bundle from execute plus the start/complete handshake to the MDU.
// The master side is the issue block; the slave side is the surrounding pipeline and MDU.
interface mdu_issue_if;

   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_op_i;
   logic [31:0] req_rs1_i;
   logic [31:0] req_rs2_i;
   logic [4:0]  req_rd_i;
   logic        flush_i;
   logic        busy_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        timeout_o;
   logic        mdu_valid_o;
   logic        mdu_ready_i;
   logic [2:0]  mdu_op_o;
   logic [31:0] mdu_rs1_o;
   logic [31:0] mdu_rs2_o;
   logic [31:0] mdu_rd_i;

   modport master (
      input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
      input  mdu_ready_i, mdu_rd_i,
      output req_ready_o, busy_o, wb_valid_o, wb_rd_o, wb_data_o, timeout_o,
      output mdu_valid_o, mdu_op_o, mdu_rs1_o, mdu_rs2_o
   );

   modport slave (
      output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
      output mdu_ready_i, mdu_rd_i,
      input  req_ready_o, busy_o, wb_valid_o, wb_rd_o, wb_data_o, timeout_o,
      input  mdu_valid_o, mdu_op_o, mdu_rs1_o, mdu_rs2_o
   );

endinterface

// File: rtl/mdu_watchdog.sv
// Hang watchdog: counts enabled cycles since the last clear and flags the cycle in
// which the TIMEOUT_CYCLES-th enabled cycle elapses.
module mdu_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign expire = en && (count_reg == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mdu_issue.sv
// Core-side issue block for the M-extension MDU: accepts one request, starts the MDU,
// holds operands until completion and emits a one-cycle writeback or watchdog pulse.
module mdu_issue
   import mdu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit DIV0_BYPASS    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   mdu_issue_if.master bus
);

   issue_state_t state;
   logic [2:0]   op_reg;
   logic [31:0]  rs1_reg;
   logic [31:0]  rs2_reg;
   logic [4:0]   rd_reg;
   logic         mdu_valid_reg;
   logic         wb_valid_reg;
   logic [4:0]   wb_rd_reg;
   logic [31:0]  wb_data_reg;
   logic         timeout_reg;
   logic         wd_clr;
   logic         wd_en;
   logic         wd_expire;

   assign wd_clr = (state == ST_ISSUE);
   assign wd_en  = (state == ST_WAIT) || (state == ST_DRAIN);

   mdu_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         op_reg        <= '0;
         rs1_reg       <= '0;
         rs2_reg       <= '0;
         rd_reg        <= '0;
         mdu_valid_reg <= 1'b0;
         wb_valid_reg  <= 1'b0;
         wb_rd_reg     <= '0;
         wb_data_reg   <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         mdu_valid_reg <= 1'b0;
         wb_valid_reg  <= 1'b0;
         timeout_reg   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid_i && !bus.flush_i) begin
                  op_reg  <= bus.req_op_i;
                  rs1_reg <= bus.req_rs1_i;
                  rs2_reg <= bus.req_rs2_i;
                  rd_reg  <= bus.req_rd_i;
                  if (DIV0_BYPASS && bus.req_op_i[2] && (bus.req_rs2_i == '0)) begin
                     state <= ST_LOCAL;
                  end else begin
                     state         <= ST_ISSUE;
                     mdu_valid_reg <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               // The start strobe has already gone out, so a flush can only drain.
               state <= bus.flush_i ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.mdu_ready_i) begin
                  state <= ST_IDLE;
                  if (!bus.flush_i && (rd_reg != '0)) begin
                     wb_valid_reg <= 1'b1;
                     wb_rd_reg    <= rd_reg;
                     wb_data_reg  <= bus.mdu_rd_i;
                  end
               end else if (wd_expire) begin
                  state       <= ST_IDLE;
                  timeout_reg <= 1'b1;
               end else if (bus.flush_i) begin
                  state <= ST_DRAIN;
               end
            end
            ST_LOCAL: begin
               state <= ST_IDLE;
               if (!bus.flush_i && (rd_reg != '0)) begin
                  wb_valid_reg <= 1'b1;
                  wb_rd_reg    <= rd_reg;
                  wb_data_reg  <= div0_result(op_reg, rs1_reg);
               end
            end
            ST_DRAIN: begin
               // Killed op: wait out the MDU so it is free for the next request.
               if (bus.mdu_ready_i) begin
                  state <= ST_IDLE;
               end else if (wd_expire) begin
                  state       <= ST_IDLE;
                  timeout_reg <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o = (state == ST_IDLE);
   assign bus.busy_o      = (state != ST_IDLE);
   assign bus.mdu_valid_o = mdu_valid_reg;
   assign bus.mdu_op_o    = op_reg;
   assign bus.mdu_rs1_o   = rs1_reg;
   assign bus.mdu_rs2_o   = rs2_reg;
   assign bus.wb_valid_o  = wb_valid_reg;
   assign bus.wb_rd_o     = wb_rd_reg;
   assign bus.wb_data_o   = wb_data_reg;
   assign bus.timeout_o   = timeout_reg;

endmodule

// File: tb/tb_mdu_issue.sv
// Scoreboard bench for mdu_issue: a stub MDU with programmable latency answers start
// strobes, a driver issues directed and random ops, and a monitor checks writebacks.
module tb_mdu_issue;

   logic clk;
   logic rst_n;

   mdu_issue_if bus();

   mdu_issue #(
      .TIMEOUT_CYCLES(64),
      .DIV0_BYPASS   (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_to;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_pass   = 0;

   int stub_lat  = 0;
   bit stub_hang = 1'b0;
   int mdu_starts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Architectural M-extension results computed with 64-bit integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      r  = '0;
      case (op)
         3'd0: begin p = ua * ub; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: r = (b == 0) ? a : 32'(sa % sb);
         default: r = (b == 0) ? a : 32'(ua % ub);
      endcase
      return r;
   endfunction

   // Stub MDU: answers each start strobe stub_lat cycles into WAIT, computing the
   // result from what the DUT presents and tracking operand stability meanwhile.
   initial begin : mdu_stub
      bit          pending;
      bit          stable_ok;
      int          wait_left;
      logic [2:0]  cap_op;
      logic [31:0] cap_a;
      logic [31:0] cap_b;
      pending   = 1'b0;
      stable_ok = 1'b1;
      wait_left = 0;
      cap_op    = '0;
      cap_a     = '0;
      cap_b     = '0;
      bus.mdu_ready_i = 1'b0;
      bus.mdu_rd_i    = '0;
      forever begin
         @(negedge clk);
         bus.mdu_ready_i = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else begin
            if (pending) begin
               if (bus.mdu_op_o !== cap_op || bus.mdu_rs1_o !== cap_a || bus.mdu_rs2_o !== cap_b)
                  stable_ok = 1'b0;
               if (wait_left == 0) begin
                  bus.mdu_ready_i = 1'b1;
                  bus.mdu_rd_i    = ref_result(cap_op, cap_a, cap_b);
                  pending         = 1'b0;
                  check("mdu_operands_stable", 32'(stable_ok), 32'd1);
               end else begin
                  wait_left--;
               end
            end
            if (bus.mdu_valid_o) begin
               mdu_starts++;
               cap_op    = bus.mdu_op_o;
               cap_a     = bus.mdu_rs1_o;
               cap_b     = bus.mdu_rs2_o;
               stable_ok = 1'b1;
               wait_left = stub_lat;
               pending   = !stub_hang;
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.wb_valid_o) begin
               if (sb.size() == 0) begin
                  check("wb_unexpected", 32'd1, 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check("wb_kind", 32'(mon_e.is_to), 32'd0);
                  check("wb_rd", {27'd0, bus.wb_rd_o}, {27'd0, mon_e.rd});
                  check("wb_data", bus.wb_data_o, mon_e.data);
               end
            end
            if (bus.timeout_o) begin
               if (sb.size() == 0) begin
                  check("timeout_unexpected", 32'd1, 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check("timeout_kind", 32'(mon_e.is_to), 32'd1);
               end
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge where the DUT can accept.
   task automatic wait_idle();
      int n;
      n = 0;
      while (!bus.req_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("wait_idle_bound", 32'd0, 32'd1);
   endtask

   // Issue one op. fk is the cycle after accept in which flush is raised (-1: none).
   // Cycle 1 is ISSUE/LOCAL, the MDU answers in cycle lat+2, the DUT is idle again
   // in cycle lat+3 (bypass: 2, watchdog: 66).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input bit hang, input int fk);
      bit    bypass;
      bit    killed;
      bit    exp_wb;
      int    c;
      int    end_c;
      int    starts0;
      exp_t  e;
      bypass = op[2] && (b == 0);
      killed = (fk >= 1) && (bypass ? (fk == 1) : (fk <= lat + 1));
      exp_wb = !killed && !hang && (rd != 0);
      end_c  = bypass ? 2 : (hang ? 66 : lat + 3);
      wait_idle();
      stub_lat  = lat;
      stub_hang = hang;
      starts0   = mdu_starts;
      if (exp_wb) begin
         e.is_to = 1'b0; e.rd = rd; e.data = ref_result(op, a, b);
         sb.push_back(e);
      end
      if (hang) begin
         e.is_to = 1'b1; e.rd = '0; e.data = '0;
         sb.push_back(e);
      end
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = op;
      bus.req_rs1_i   = a;
      bus.req_rs2_i   = b;
      bus.req_rd_i    = rd;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      for (c = 1; c < 300; c++) begin
         @(negedge clk);
         if (!bus.busy_o) break;
         bus.flush_i = (c == fk);
      end
      bus.flush_i = 1'b0;
      check("end_cycle", 32'(c), 32'(end_c));
      check("wb_strobe_timing", 32'(bus.wb_valid_o), 32'(exp_wb));
      check("timeout_timing", 32'(bus.timeout_o), 32'(hang));
      check("mdu_start_count", 32'(mdu_starts - starts0), bypass ? 32'd0 : 32'd1);
      $display("op=%0d a=%h b=%h rd=%0d lat=%0d hang=%0d flush_at=%0d end=%0d",
               op, a, b, rd, lat, hang, fk, c);
   endtask

   initial begin : global_bound
      #2_000_000;
      $display("FAIL global_time_limit actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin : driver
      int          starts0;
      logic [2:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      int          r_lat;
      int          r_fk;
      bus.req_valid_i = 1'b0;
      bus.req_op_i    = '0;
      bus.req_rs1_i   = '0;
      bus.req_rs2_i   = '0;
      bus.req_rd_i    = '0;
      bus.flush_i     = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_mdu_valid", 32'(bus.mdu_valid_o), 32'd0);
      check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
      check("rst_timeout", 32'(bus.timeout_o), 32'd0);
      check("rst_mdu_rs1", bus.mdu_rs1_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3'd0, 32'd7, 32'd6, 5'd5, 3, 1'b0, -1);                      // MUL 7*6
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 34, 1'b0, -1);             // DIV -7/2
      run_op(3'd5, 32'd9, 32'd0, 5'd3, 0, 1'b0, -1);                      // DIVU 9/0
      run_op(3'd7, 32'd9, 32'd0, 5'd4, 0, 1'b0, -1);                      // REMU 9/0
      run_op(3'd4, 32'd100, 32'd3, 5'd8, 30, 1'b0, 3);                    // flush in WAIT
      run_op(3'd0, 32'd2, 32'd3, 5'd9, 5, 1'b0, 1);                       // flush in ISSUE
      run_op(3'd4, 32'd5, 32'd0, 5'd10, 0, 1'b0, 1);                      // flush in LOCAL
      run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 2, 1'b0, -1);      // rd==0
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 1'b0, -1);     // DIV overflow
      run_op(3'd6, 32'd1, 32'd0, 5'd12, 0, 1'b0, -1);                     // REM x/0
      run_op(3'd0, 32'd1, 32'd1, 5'd13, 0, 1'b1, -1);                     // stub hangs

      // flush together with valid: nothing is accepted
      wait_idle();
      starts0 = mdu_starts;
      bus.req_valid_i = 1'b1; bus.flush_i = 1'b1;
      bus.req_op_i = 3'd0; bus.req_rs1_i = 32'd4; bus.req_rs2_i = 32'd4; bus.req_rd_i = 5'd14;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
      @(negedge clk);
      check("flush_wins_busy", 32'(bus.busy_o), 32'd0);
      repeat (3) @(negedge clk);
      check("flush_wins_no_start", 32'(mdu_starts - starts0), 32'd0);
      $display("flush with valid: busy=%0d starts=%0d", bus.busy_o, mdu_starts - starts0);

      // asynchronous reset in the middle of WAIT
      stub_hang = 1'b1;
      bus.req_valid_i = 1'b1;
      bus.req_op_i = 3'd4; bus.req_rs1_i = 32'd100; bus.req_rs2_i = 32'd7; bus.req_rd_i = 5'd6;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(bus.busy_o), 32'd0);
      check("async_rst_req_ready", 32'(bus.req_ready_o), 32'd1);
      check("async_rst_mdu_op", {29'd0, bus.mdu_op_o}, 32'd0);
      check("async_rst_mdu_rs2", bus.mdu_rs2_o, 32'd0);
      $display("async reset mid-WAIT: busy=%0d ready=%0d", bus.busy_o, bus.req_ready_o);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stub_hang = 1'b0;
      @(negedge clk);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 4, 1'b0, -1);    // MULHU

      for (int i = 0; i < 40; i++) begin
         r_op  = 3'($urandom_range(0, 7));
         r_a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         r_b   = ($urandom_range(0, 3) == 0) ? 32'd0 :
                 (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
         r_lat = $urandom_range(0, 40);
         r_fk  = -1;
         if ($urandom_range(0, 4) == 0)
            r_fk = (r_op[2] && r_b == 0) ? 1 : $urandom_range(1, r_lat + 1);
         run_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)), r_lat, 1'b0, r_fk);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
